// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: walks the framebuffer row by row and bit-plane by bit-plane
// (binary-coded modulation), serves one pixel pair per column request from the
// HUB75 driver, and orders latch/show with plane p lit for BASE_SHOW<<p cycles.
// Shifting of the next plane overlaps the on-period of the current one.
module hub75_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int ROWS      = 32,
  parameter int PLANES    = 4,
  parameter int BASE_SHOW = 16,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ADDR_W   = ROW_W + COL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_ENABLE,
  input  logic                  in_ITER,
  input  logic                  in_WAITING,
  output logic [ADDR_W-1:0]     out_MEM_ADDR,
  input  logic [6*PLANES-1:0]   in_MEM_DATA,
  output logic                  out_INIT,
  output logic [2:0]            out_RGB0,
  output logic [2:0]            out_RGB1,
  output logic [4:0]            out_ROW,
  output logic                  out_SHOW,
  output logic                  out_BRIGHT_DIM,
  output logic                  out_FRAME_DONE
);

  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int MAX_T   = BASE_SHOW << (PLANES - 1);
  localparam int TIMER_W = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    READY,
    SHOW
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   rowShift_q, rowShift_d;
  logic [PLANE_W-1:0] planeShift_q, planeShift_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ROW_W-1:0]   showRow_q, showRow_d;
  logic               init_q, init_d;

  // State and datapath registers; everything returns to the idle scan origin on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rowShift_q   <= '0;
      planeShift_q <= '0;
      col_q        <= '0;
      timer_q      <= '0;
      showRow_q    <= '0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rowShift_q   <= rowShift_d;
      planeShift_q <= planeShift_d;
      col_q        <= col_d;
      timer_q      <= timer_d;
      showRow_q    <= showRow_d;
      init_q       <= init_d;
    end
  end

  // Next-state logic: scan sequencing, pointer advance and on-period timer.
  always_comb begin
    state_d        = state_q;
    rowShift_d     = rowShift_q;
    planeShift_d   = planeShift_q;
    col_d          = col_q;
    showRow_d      = showRow_q;
    init_d         = 1'b0;
    out_SHOW       = 1'b0;
    out_FRAME_DONE = 1'b0;
    timer_d        = (timer_q != '0) ? timer_q - 1'b1 : timer_q;

    case (state_q)
      IDLE: begin
        if (in_ENABLE) state_d = LOAD;
      end
      LOAD: begin
        col_d   = '0;
        init_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (in_ITER) begin
          if (col_q == COL_W'(COLS - 1)) state_d = READY;
          else                           col_d   = col_q + 1'b1;
        end
      end
      READY: begin
        if (in_WAITING && (timer_q == '0)) state_d = SHOW;
      end
      SHOW: begin
        out_SHOW  = 1'b1;
        showRow_d = rowShift_q;
        timer_d   = TIMER_W'(BASE_SHOW) << planeShift_q;
        if (planeShift_q == PLANE_W'(PLANES - 1)) begin
          planeShift_d = '0;
          if (rowShift_q == ROW_W'(ROWS - 1)) begin
            rowShift_d     = '0;
            out_FRAME_DONE = 1'b1;
          end else begin
            rowShift_d = rowShift_q + 1'b1;
          end
        end else begin
          planeShift_d = planeShift_q + 1'b1;
        end
        state_d = in_ENABLE ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel bit-select for the plane being shifted; data layout is {R0,G0,B0,R1,G1,B1}.
  always_comb begin
    int p;
    p        = int'(planeShift_q);
    out_RGB0 = {in_MEM_DATA[5*PLANES + p], in_MEM_DATA[4*PLANES + p], in_MEM_DATA[3*PLANES + p]};
    out_RGB1 = {in_MEM_DATA[2*PLANES + p], in_MEM_DATA[1*PLANES + p], in_MEM_DATA[p]};
  end

  assign out_MEM_ADDR   = {rowShift_q, col_q};
  assign out_INIT       = init_q;
  assign out_ROW        = 5'(showRow_q);
  assign out_BRIGHT_DIM = (timer_q == '0);

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl: directed bench with a small HUB75 driver model. Instance A
// uses the default geometry; instance B uses a tiny 2-row, 2-plane, 4-column
// geometry so a whole frame wrap can be observed.
module tb_hub75_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enA = 1'b0, enB = 1'b0;
  logic iter = 1'b0, waiting = 1'b0, sel = 1'b0;

  logic [10:0] addrA;
  logic [23:0] memA = '0;
  logic        initA, showA, dimA, fdA;
  logic [2:0]  rgb0A, rgb1A;
  logic [4:0]  rowA;

  logic [2:0]  addrB;
  logic [11:0] memB = '0;
  logic        initB, showB, dimB, fdB;
  logic [2:0]  rgb0B, rgb1B;
  logic [4:0]  rowB;

  logic [31:0] addrObs;
  logic        initObs, showObs, dimObs, fdObs;
  logic [2:0]  rgb0Obs;
  logic [4:0]  rowObs;

  int testCount = 0;
  int failCount = 0;
  int runLen = 0;
  int runs[$];
  int fdCount = 0;

  always #5 clk = ~clk;

  hub75_scan_ctrl dutA (
    .clk(clk), .rst(rst), .in_ENABLE(enA), .in_ITER(iter & ~sel), .in_WAITING(waiting & ~sel),
    .out_MEM_ADDR(addrA), .in_MEM_DATA(memA), .out_INIT(initA), .out_RGB0(rgb0A), .out_RGB1(rgb1A),
    .out_ROW(rowA), .out_SHOW(showA), .out_BRIGHT_DIM(dimA), .out_FRAME_DONE(fdA)
  );

  hub75_scan_ctrl #(.COLS(4), .ROWS(2), .PLANES(2), .BASE_SHOW(16)) dutB (
    .clk(clk), .rst(rst), .in_ENABLE(enB), .in_ITER(iter & sel), .in_WAITING(waiting & sel),
    .out_MEM_ADDR(addrB), .in_MEM_DATA(memB), .out_INIT(initB), .out_RGB0(rgb0B), .out_RGB1(rgb1B),
    .out_ROW(rowB), .out_SHOW(showB), .out_BRIGHT_DIM(dimB), .out_FRAME_DONE(fdB)
  );

  assign addrObs = sel ? 32'(addrB) : 32'(addrA);
  assign initObs = sel ? initB : initA;
  assign showObs = sel ? showB : showA;
  assign dimObs  = sel ? dimB  : dimA;
  assign fdObs   = sel ? fdB   : fdA;
  assign rgb0Obs = sel ? rgb0B : rgb0A;
  assign rowObs  = sel ? rowB  : rowA;

  // Framebuffer image: R0 at column 5 is 4'b1010, other fields follow the address.
  function automatic logic [23:0] pixA(input logic [10:0] a);
    logic [3:0] r0;
    r0 = (a[5:0] == 6'd5) ? 4'b1010 : a[3:0];
    return {r0, a[7:4], a[3:0], ~a[3:0], 4'h6, a[9:6]};
  endfunction

  // Synchronous read ports: data valid one clock after the address.
  always @(posedge clk) begin
    memA <= pixA(addrA);
    memB <= 12'b10_01_11_00_10_01;
  end

  // Length of each dim-low stretch of instance A, i.e. each plane's on-period.
  always @(negedge clk) begin
    if (!rst) runLen = 0;
    else if (!dimA) runLen++;
    else if (runLen != 0) begin
      runs.push_back(runLen);
      runLen = 0;
    end
  end

  always @(negedge clk) if (fdB) fdCount++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Counts cycles until out_INIT is seen (bounded).
  task automatic waitInit(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!initObs && n < 400);
    checkOutput("init_seen", 32'(initObs), 1);
  endtask

  // Driver model: consumes one column every two cycles, checking the address.
  task automatic shiftPlane(input int cols, input int rowExp, input int rgbCol, input int abortCol,
                            output int addrErr, output logic rgbBit);
    addrErr = 0;
    rgbBit  = 1'b0;
    for (int c = 0; c < cols; c++) begin
      tick();
      if (addrObs !== 32'(rowExp * cols + c)) addrErr++;
      if (c == rgbCol) rgbBit = rgb0Obs[2];
      if (c == abortCol) return;
      iter = 1'b1;
      tick();
      iter = 1'b0;
    end
  endtask

  // Driver waits 'delay' cycles before WAITING, then waits for the show order.
  task automatic showPlane(input int delay, output int lat, output int badDim, output int extraInit);
    logic seenHigh;
    seenHigh  = 1'b0;
    badDim    = 0;
    extraInit = 0;
    repeat (delay) begin
      tick();
      if (initObs) extraInit++;
      if (dimObs) seenHigh = 1'b1;
      else if (seenHigh) badDim++;
    end
    waiting = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (initObs) extraInit++;
      if (seenHigh && !dimObs) badDim++;
    end while (!showObs && lat < 400);
    waiting = 1'b0;
    checkOutput("show_seen", 32'(showObs), 1);
  endtask

  initial begin
    int n, err, lat, badDim, extraInit;
    logic bitv;
    logic rgbBits [4];
    logic fdAtShow [4];

    // Reset values
    repeat (3) tick();
    checkOutput("rst_addr", addrObs, 0);
    checkOutput("rst_init", 32'(initObs), 0);
    checkOutput("rst_show", 32'(showObs), 0);
    checkOutput("rst_dim", 32'(dimObs), 1);
    checkOutput("rst_row", 32'(rowObs), 0);
    checkOutput("rst_frame_done", 32'(fdObs), 0);
    rst = 1'b1;
    tick();

    // Row 0, planes 0..3 with a prompt driver
    enA = 1'b1;
    waitInit(n);
    checkOutput("init_latency", n, 2);
    checkOutput("init_addr", addrObs, 0);
    for (int p = 0; p < 4; p++) begin
      shiftPlane(64, 0, 5, -1, err, bitv);
      checkOutput("addr_steps_row0", err, 0);
      rgbBits[p] = bitv;
      showPlane(0, lat, badDim, extraInit);
      if (p == 0) checkOutput("show_latency", lat, 1);
      checkOutput("row_after_show", 32'(rowObs), 0);
      waitInit(n);
      checkOutput("next_init_latency", n, 2);
      checkOutput("next_init_addr", addrObs, (p == 3) ? 64 : 0);
    end
    checkOutput("rgb_plane0", 32'(rgbBits[0]), 0);
    checkOutput("rgb_plane1", 32'(rgbBits[1]), 1);
    checkOutput("rgb_plane2", 32'(rgbBits[2]), 0);
    checkOutput("rgb_plane3", 32'(rgbBits[3]), 1);

    // Row 1 plane 0 with a slow driver: panel blanked until the show order
    shiftPlane(64, 1, -1, -1, err, bitv);
    checkOutput("addr_steps_row1", err, 0);
    showPlane(200, lat, badDim, extraInit);
    checkOutput("slow_show_latency", lat, 1);
    checkOutput("slow_dim_gap", badDim, 0);
    checkOutput("slow_extra_init", extraInit, 0);
    checkOutput("slow_dim_at_show", 32'(dimObs), 1);
    tick();
    checkOutput("row1_shown", 32'(rowObs), 1);

    // On-period of each plane of row 0
    checkOutput("run_count", runs.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("on_time_plane%0d", i), (i < runs.size()) ? runs[i] : 0, 16 << i);

    // Asynchronous reset in the middle of a shift at column 30
    waitInit(n);
    shiftPlane(64, 1, -1, 30, err, bitv);
    checkOutput("addr_before_reset", err, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_addr", addrObs, 0);
    checkOutput("mid_rst_init", 32'(initObs), 0);
    checkOutput("mid_rst_show", 32'(showObs), 0);
    checkOutput("mid_rst_dim", 32'(dimObs), 1);
    checkOutput("mid_rst_row", 32'(rowObs), 0);
    checkOutput("mid_rst_frame_done", 32'(fdObs), 0);
    tick();
    rst = 1'b1;
    waitInit(n);
    checkOutput("restart_init_latency", n, 2);
    checkOutput("restart_addr", addrObs, 0);
    shiftPlane(64, 0, 5, -1, err, bitv);
    checkOutput("restart_addr_steps", err, 0);
    checkOutput("restart_rgb_plane0", 32'(bitv), 0);
    enA = 1'b0;
    showPlane(0, lat, badDim, extraInit);
    tick();

    // Frame wrap on the small instance: 2 rows x 2 planes
    sel = 1'b1;
    enB = 1'b1;
    waitInit(n);
    for (int k = 0; k < 4; k++) begin
      shiftPlane(4, k / 2, 1, -1, err, bitv);
      checkOutput("wrap_addr_steps", err, 0);
      showPlane(0, lat, badDim, extraInit);
      fdAtShow[k] = fdObs;
      waitInit(n);
    end
    checkOutput("wrap_frame_done_count", fdCount, 1);
    checkOutput("wrap_frame_done_at_show4", 32'(fdAtShow[3]), 1);
    checkOutput("wrap_init_addr", addrObs, 0);
    shiftPlane(4, 0, 1, -1, err, bitv);
    checkOutput("wrap_addr_steps_next", err, 0);
    checkOutput("wrap_plane0_rgb", 32'(bitv), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Upstream sequencer for the HUB75 panel driver.
- Walks the framebuffer row by row and bit-plane by bit-plane using binary-coded modulation (BCM), serves one pixel pair per column-shift request, and orders latch/show.
- Times each plane's on-period so that plane p is lit for BASE_SHOW<<p cycles, with the next plane's data shifted in while the current one is displayed.
- Sits between the framebuffer read port and the HUB75 driver's INIT/RGB/ROW/SHOW/BRIGHT_DIM inputs.

Parameters:
- COLS, 64, pixels per row shifted per plane.
- ROWS, 32, row-pair addresses (upper half plus lower half of the panel).
- PLANES, 4, bits per colour channel.
- BASE_SHOW, 16, on-time in clk cycles of plane 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_ENABLE  in  1  level; 1 = keep scanning frames.
- in_ITER  in  1  one-cycle pulse from the driver: current column consumed, present next.
- in_WAITING  in  1  driver has finished shifting and is waiting for the show order.
- out_MEM_ADDR  out  log2(ROWS*COLS)  framebuffer address = {row_shift, col}.
- in_MEM_DATA  in  6*PLANES  read data, valid 1 clk after the address. Layout {R0,G0,B0,R1,G1,B1}, each PLANES bits, MSB first.
- out_INIT  out  1  one-cycle pulse: start shifting a row/plane.
- out_RGB0  out  3  upper-half pixel bits of current plane.
- out_RGB1  out  3  lower-half pixel bits of current plane.
- out_ROW  out  5  row currently displayed.
- out_SHOW  out  1  one-cycle pulse: latch and display.
- out_BRIGHT_DIM  out  1  1 = blank while the driver waits.
- out_FRAME_DONE  out  1  one-cycle pulse after the last row/plane is shown.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; row_shift=0, plane_shift=0, col=0, timer=0, out_ROW=0; all pulse outputs 0; out_BRIGHT_DIM=1; out_MEM_ADDR=0.
- RGB outputs: out_RGB0/1 are combinational bit-selects of in_MEM_DATA at index plane_shift.
- FSM states: IDLE, LOAD, SHIFT, READY, SHOW.
  - IDLE: when in_ENABLE=1, go to LOAD. Address 0 is already on the bus.
  - LOAD: out_INIT=1 for exactly one cycle; col=0; go to SHIFT.
  - SHIFT: on in_ITER, col increments and out_MEM_ADDR updates the same edge; data is valid the next cycle. The driver guarantees in_ITER spacing of at least 2 cycles. When col==COLS-1 and in_ITER arrives, col holds; go to READY.
  - READY: wait until in_WAITING=1 and timer==0, then go to SHOW.
  - SHOW (1 cycle):
    - out_SHOW=1; out_ROW<=row_shift; timer<=BASE_SHOW<<plane_shift.
    - Advance the shift pointers: plane+1; if plane==PLANES-1, plane=0 and row+1; if row==ROWS-1 as well, row=0 and out_FRAME_DONE=1 this cycle.
    - Go to LOAD if in_ENABLE, else IDLE.
- Timer: decrements by 1 every cycle while nonzero, in any state. The timer width must hold BASE_SHOW<<(PLANES-1) with no overflow (default 128 needs 8 bits).
- out_BRIGHT_DIM = (timer==0). This blanks the panel when the on-period has expired but the next plane is not yet ready, which keeps BCM weights exact.
- Pipelining: the LOAD/SHIFT of plane k+1 overlaps the timer of plane k. out_ROW changes only in SHOW, so displayed data and address stay consistent.
- in_ENABLE dropping mid-frame: the in-progress row/plane completes through SHOW, then the FSM goes to IDLE. Pointers are kept, so a re-enable resumes from the next plane.
- in_ITER outside SHIFT: ignored.
- in_WAITING before timer==0: hold in READY.
- Reset mid-shift: immediate return to reset values; the driver is re-initialised by the next out_INIT.

Test Plan:
- Reset then in_ENABLE=1, driver model echoing 64 in_ITER pulses and asserting WAITING:
  - out_INIT occurs 2 cycles after enable.
  - out_MEM_ADDR steps 0..63.
  - out_SHOW occurs 1 cycle after WAITING.
  - out_ROW=0; timer load is 16.
- Plane timing: measure clk cycles between out_BRIGHT_DIM falling and rising for planes 0..3 of row 0 -> 16, 32, 64, 128 respectively.
- RGB bit-select: in_MEM_DATA with R0=4'b1010 at col 5 -> out_RGB0[2] reads 0,1,0,1 for planes 0..3.
- Wrap: run a full frame with ROWS=2, PLANES=2, COLS=4:
  - out_FRAME_DONE pulses once, coincident with the 4th out_SHOW.
  - The next INIT uses row 0, plane 0.
- Slow driver: WAITING delayed 200 cycles after plane 0 shift -> out_BRIGHT_DIM=1 from timer expiry until out_SHOW; no extra INIT is issued.
- Async reset asserted during SHIFT at col 30, without a clk edge -> all outputs go to reset values immediately. After release with enable, scanning restarts at address 0.
